// File: rtl/adc_avg_decim.sv
// adc_avg_decim
// Boxcar decimator for the converter output code. Consecutive valid samples
// are grouped into windows of 2^LOG2_N; each window produces its truncated
// mean and its peak sample. Results are offered through a one-deep
// valid/ready output register. A result that closes while that register is
// still full and not being drained is dropped and counted.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_en         run enable; low aborts the partial window and idles
//   i_din_valid  i_din carries a new sample this cycle
//   i_din        unsigned converter code (DW bits)
//   o_avg_valid  o_avg/o_peak hold a result
//   i_avg_ready  consumer accepts the result this cycle
//   o_avg        window mean, truncated (DW bits)
//   o_peak       maximum sample of the window (DW bits)
//   o_ovf_cnt    saturating count of dropped results (OVF_W bits)
//   o_busy       a window is partially accumulated
module adc_avg_decim #(
  parameter int DW     = 10,
  parameter int LOG2_N = 2,
  parameter int OVF_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_din_valid,
  input  logic [DW-1:0]    i_din,
  output logic             o_avg_valid,
  input  logic             i_avg_ready,
  output logic [DW-1:0]    o_avg,
  output logic [DW-1:0]    o_peak,
  output logic [OVF_W-1:0] o_ovf_cnt,
  output logic             o_busy
);

  // The accumulator is wide enough to hold N full-scale samples, so it can
  // never wrap.
  localparam int ACCW = DW + LOG2_N;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [ACCW-1:0]     r_acc;
  logic [DW-1:0]       r_max;
  logic [LOG2_N-1:0]   r_cnt;
  logic                r_avgValid;
  logic [DW-1:0]       r_avg;
  logic [DW-1:0]       r_peak;
  logic [OVF_W-1:0]    r_ovfCnt;

  logic                w_accept;
  logic                w_close;
  logic [ACCW-1:0]     w_sum;
  logic [DW-1:0]       w_maxNew;
  logic                w_canLoad;

  // State register: tracks whether the block is running or idling.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Enable alone decides the mode; dropping enable sends
  // the block to IDLE, which discards the partial window at that edge.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_en)  w_nextState = ACCUM;
      ACCUM:   if (!i_en) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A sample is taken on any edge where the block will be accumulating, so
  // the sample presented together with the rising enable is not lost.
  // The window closes on the edge that accepts the last sample of N; the sum
  // and peak include that sample directly so no gap cycle is needed.
  always_comb begin
    w_accept  = (w_nextState == ACCUM) && i_din_valid;
    w_close   = w_accept && (r_cnt == {LOG2_N{1'b1}});
    w_sum     = r_acc + ACCW'(i_din);
    w_maxNew  = (i_din > r_max) ? i_din : r_max;
    w_canLoad = !r_avgValid || i_avg_ready;
  end

  // Window datapath: accumulator, running maximum and sample counter.
  // All three are held at zero while idle and restart on window close.
  always_ff @(posedge i_clk) begin
    if (i_rst || (w_nextState == IDLE) || w_close) begin
      r_acc <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_max <= w_maxNew;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // One-deep output register. A closing window loads if the register is
  // empty or being drained on this same edge, which gives one result per
  // edge back-to-back. Otherwise the new result is dropped, the held one is
  // kept stable, and the saturating drop counter advances. Enable has no
  // effect here so a pending result can still drain while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_avgValid <= 1'b0;
      r_avg      <= '0;
      r_peak     <= '0;
      r_ovfCnt   <= '0;
    end else begin
      if (w_close && w_canLoad) begin
        r_avgValid <= 1'b1;
        r_avg      <= w_sum[ACCW-1:LOG2_N];
        r_peak     <= w_maxNew;
      end else if (r_avgValid && i_avg_ready) begin
        r_avgValid <= 1'b0;
      end
      if (w_close && !w_canLoad && (r_ovfCnt != {OVF_W{1'b1}})) begin
        r_ovfCnt <= r_ovfCnt + 1'b1;
      end
    end
  end

  assign o_avg_valid = r_avgValid;
  assign o_avg       = r_avg;
  assign o_peak      = r_peak;
  assign o_ovf_cnt   = r_ovfCnt;
  assign o_busy      = (r_cnt != '0);

endmodule

// File: doc/adc_avg_decim.md
Name: adc_avg_decim

Overview:
Downstream consumer of the 10-bit converter output code. It averages fixed-size windows of 2^LOG2_N consecutive valid samples (boxcar decimation) and tracks the window peak. Each result is presented through a one-deep valid/ready output register to the next stage, for example a logger or the DAC drive path. Dropped results are counted when the consumer stalls.

Parameters:
DW, 10, sample and result width in bits
LOG2_N, 2, log2 of window length (N = 4 samples per result); legal range 1..6
OVF_W, 8, width of the saturating dropped-result counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  run enable; low aborts and holds the window in IDLE
din_valid  in  1  din carries a new sample this cycle
din  in  DW  unsigned converter code
avg_valid  out  1  avg/peak hold a result
avg_ready  in  1  consumer accepts the result this cycle
avg  out  DW  window mean, truncated
peak  out  DW  maximum sample in the window
ovf_cnt  out  OVF_W  results dropped while the output register was full; saturating
busy  out  1  high while a window is partially accumulated (sample count != 0)

Behaviour:
- Reset (rst=1 at a clk edge): avg_valid=0, avg=0, peak=0, ovf_cnt=0, busy=0. The accumulator, the running max and the sample counter clear to 0. rst overrides all other inputs, including a mid-window reset; the partial window is discarded.
- States:
  - IDLE (en=0): accumulator, running max and counter are held at 0. din is ignored.
  - ACCUM (en=1).
  - Transitions: IDLE->ACCUM when en=1. ACCUM->IDLE when en=0, which discards the partial window at that edge.
  - The output register and ovf_cnt are unaffected by en. A pending result can still be drained while en=0.
- Accumulation (ACCUM, din_valid=1):
  - acc += din. Accumulator width is DW+LOG2_N, so it cannot overflow (4 x 1023 = 4092 fits in 12 bits).
  - max = max(max, din).
  - cnt increments and wraps at N.
  - din_valid=0 cycles are ignored; there is no timeout.
- Window close: on the edge where the Nth valid sample (cnt==N-1) is accepted:
  - result = (acc + din) >> LOG2_N, truncated, never rounded;
  - result peak = max(max, din);
  - acc, max and cnt clear at that same edge, so the next sample starts a new window with no gap cycle.
- Latency: avg_valid rises at the clk edge that accepts the Nth sample, i.e. it is visible the cycle after that sample is presented.
- Output handshake:
  - A transfer occurs on an edge where avg_valid & avg_ready.
  - avg and peak are stable while avg_valid=1 and avg_ready=0.
  - avg_valid falls after a transfer unless a new result loads at the same edge.
- Simultaneous close and transfer: the new result loads and avg_valid stays 1 (back-to-back throughput of one result per edge).
- Close while full and not ready: the new result is dropped, the old result is held, and ovf_cnt increments, saturating at 2^OVF_W-1 (never wraps).
- busy = (cnt != 0).

Test Plan:
- Basic average: rst, en=1, din 100,200,300,400 on consecutive valid cycles, avg_ready=1 -> avg_valid pulses 1 cycle after the 4th sample; avg=250, peak=400, ovf_cnt=0.
- Truncation and full scale:
  - din 1,1,1,2 -> avg=1, peak=2;
  - then 1023 x4 -> avg=1023, peak=1023, with no accumulator wrap.
- Gapped input: samples 8,8,8,8 with din_valid=0 cycles interleaved, busy high between samples -> a single result avg=8; busy=0 after the 4th sample.
- Backpressure: avg_ready=0, two windows (10 x4, then 20 x4) -> avg=10 held stable, ovf_cnt=1; raise avg_ready -> avg_valid drops next edge. Then a result closing on the same edge as a transfer -> avg_valid stays 1 with the new value.
- Saturation: OVF_W=8, avg_ready=0, 300 windows closed -> ovf_cnt=255 and stays at 255.
- Abort:
  - en low after 2 samples (busy=1) -> busy=0 next edge; re-enable, samples 4,4,4,4 -> avg=4 (old partial window not included).
  - Repeat the same sequence using rst in place of en -> all outputs are 0 after the rst edge.
